// File: rtl/memory_bus_fabric.sv
// Round-robin fabric joining NUM_CLIENTS requesters to one memory port, with a
// request FIFO toward memory and an in-order, source-routed response FIFO back.

module memory_bus_fabric_checker #(
    parameter int NUM_CLIENTS = 4
) (
    input logic                   i_clk,
    input logic                   i_reset,
    input logic                   i_req_push,
    input logic                   i_req_full,
    input logic                   i_req_pop,
    input logic                   i_req_empty,
    input logic                   i_rsp_push,
    input logic                   i_rsp_full,
    input logic                   i_rsp_pop,
    input logic                   i_rsp_empty,
    input logic [NUM_CLIENTS-1:0] i_cl_req_ready
);
    a_req_no_overflow:  assert property (@(posedge i_clk) disable iff (i_reset) !(i_req_push && i_req_full));
    a_req_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset) !(i_req_pop && i_req_empty));
    a_rsp_no_overflow:  assert property (@(posedge i_clk) disable iff (i_reset) !(i_rsp_push && i_rsp_full));
    a_rsp_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset) !(i_rsp_pop && i_rsp_empty));
    a_grant_onehot0:    assert property (@(posedge i_clk) $onehot0(i_cl_req_ready));
endmodule

module memory_bus_fabric #(
    parameter int NUM_CLIENTS = 4,
    parameter int SRC_W       = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int REQ_DEPTH   = 4,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        cl_req_valid,
    output logic [NUM_CLIENTS-1:0]        cl_req_ready,
    input  logic [2*NUM_CLIENTS-1:0]      cl_req_cmd,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_req_addr,
    input  logic [DATA_W*NUM_CLIENTS-1:0] cl_req_data,
    output logic [NUM_CLIENTS-1:0]        cl_rsp_valid,
    input  logic [NUM_CLIENTS-1:0]        cl_rsp_ready,
    output logic [DATA_W-1:0]             cl_rsp_data,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [1:0]                    mem_req_cmd,
    output logic [SRC_W-1:0]              mem_req_src,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_data,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [SRC_W-1:0]              mem_rsp_src,
    input  logic [DATA_W-1:0]             mem_rsp_data,
    output logic [$clog2(REQ_DEPTH):0]    req_count,
    output logic                          err_sticky
);
    localparam int CL_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [CL_W-1:0]   CL_LAST  = CL_W'(NUM_CLIENTS - 1);
    localparam logic [REQ_AW:0]   REQ_FULL = (REQ_AW + 1)'(REQ_DEPTH);
    localparam logic [RSP_AW:0]   RSP_FULL = (RSP_AW + 1)'(RSP_DEPTH);

    logic [1:0]        r_req_cmd  [REQ_DEPTH];
    logic [SRC_W-1:0]  r_req_src  [REQ_DEPTH];
    logic [ADDR_W-1:0] r_req_addr [REQ_DEPTH];
    logic [DATA_W-1:0] r_req_data [REQ_DEPTH];
    logic [SRC_W-1:0]  r_rsp_src  [RSP_DEPTH];
    logic [DATA_W-1:0] r_rsp_data [RSP_DEPTH];

    logic [REQ_AW-1:0] r_req_wr, r_req_rd;
    logic [REQ_AW:0]   r_req_count;
    logic [RSP_AW-1:0] r_rsp_wr, r_rsp_rd;
    logic [RSP_AW:0]   r_rsp_count;
    logic [CL_W-1:0]   r_rr_ptr;
    logic              r_err;

    logic [1:0]             w_cl_cmd  [NUM_CLIENTS];
    logic [ADDR_W-1:0]      w_cl_addr [NUM_CLIENTS];
    logic [DATA_W-1:0]      w_cl_data [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_cl_req_ready;
    logic [NUM_CLIENTS-1:0] w_cl_rsp_valid;
    logic [CL_W-1:0]        w_scan_idx, w_grant_idx, w_rr_next;
    logic                   w_grant_any, w_req_accept, w_req_push, w_req_pop, w_req_err;
    logic                   w_req_full, w_req_empty, w_mem_req_valid;
    logic                   w_rsp_room, w_rsp_hs, w_rsp_src_ok, w_rsp_push, w_rsp_pop, w_rsp_err;
    logic                   w_rsp_head_valid, w_rsp_full, w_rsp_empty;
    logic [1:0]             w_sel_cmd;

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        assign w_cl_cmd[gi]       = cl_req_cmd[2*gi +: 2];
        assign w_cl_addr[gi]      = cl_req_addr[ADDR_W*gi +: ADDR_W];
        assign w_cl_data[gi]      = cl_req_data[DATA_W*gi +: DATA_W];
        assign w_cl_rsp_valid[gi] = w_rsp_head_valid && (r_rsp_src[r_rsp_rd] == SRC_W'(gi));
    end

    // Round-robin search from the pointer upward, wrapping past the last client.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_scan_idx = CL_W'((int'(r_rr_ptr) + k) % NUM_CLIENTS);
            if (!w_grant_any && cl_req_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end else begin
                w_grant_any = w_grant_any;
            end
        end
    end

    // Fullness uses the registered count only; a same-cycle pop does not free a slot.
    assign w_req_full      = (r_req_count == REQ_FULL);
    assign w_req_empty     = (r_req_count == '0);
    assign w_req_accept    = !reset && w_grant_any && !w_req_full;
    assign w_sel_cmd       = w_cl_cmd[w_grant_idx];
    assign w_req_push      = w_req_accept && !w_sel_cmd[1];
    assign w_req_err       = w_req_accept && w_sel_cmd[1];
    assign w_mem_req_valid = !reset && !w_req_empty;
    assign w_req_pop       = w_mem_req_valid && mem_req_ready;
    assign w_rr_next       = (w_grant_idx == CL_LAST) ? '0 : w_grant_idx + CL_W'(1);

    always_comb begin
        w_cl_req_ready = '0;
        if (w_req_accept) begin
            w_cl_req_ready[w_grant_idx] = 1'b1;
        end else begin
            w_cl_req_ready = '0;
        end
    end

    assign w_rsp_full       = (r_rsp_count == RSP_FULL);
    assign w_rsp_empty      = (r_rsp_count == '0);
    assign w_rsp_room       = !reset && !w_rsp_full;
    assign w_rsp_hs         = mem_rsp_valid && w_rsp_room;
    assign w_rsp_src_ok     = (int'(mem_rsp_src) < NUM_CLIENTS);
    assign w_rsp_push       = w_rsp_hs && w_rsp_src_ok;
    assign w_rsp_err        = w_rsp_hs && !w_rsp_src_ok;
    assign w_rsp_head_valid = !reset && !w_rsp_empty;
    assign w_rsp_pop        = |(w_cl_rsp_valid & cl_rsp_ready);

    // Control state: pointers, occupancy, arbitration pointer and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_req_wr    <= '0;
            r_req_rd    <= '0;
            r_req_count <= '0;
            r_rsp_wr    <= '0;
            r_rsp_rd    <= '0;
            r_rsp_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_req_accept) r_rr_ptr <= w_rr_next;
            if (w_req_push)   r_req_wr <= r_req_wr + REQ_AW'(1);
            if (w_req_pop)    r_req_rd <= r_req_rd + REQ_AW'(1);
            if (w_rsp_push)   r_rsp_wr <= r_rsp_wr + RSP_AW'(1);
            if (w_rsp_pop)    r_rsp_rd <= r_rsp_rd + RSP_AW'(1);
            case ({w_req_push, w_req_pop})
                2'b10:   r_req_count <= r_req_count + (REQ_AW + 1)'(1);
                2'b01:   r_req_count <= r_req_count - (REQ_AW + 1)'(1);
                default: r_req_count <= r_req_count;
            endcase
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + (RSP_AW + 1)'(1);
                2'b01:   r_rsp_count <= r_rsp_count - (RSP_AW + 1)'(1);
                default: r_rsp_count <= r_rsp_count;
            endcase
            if (w_req_err || w_rsp_err) r_err <= 1'b1;
        end
    end

    // Packet storage; contents are meaningless until the matching count says otherwise.
    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_cmd[r_req_wr]  <= w_sel_cmd;
            r_req_src[r_req_wr]  <= SRC_W'(w_grant_idx);
            r_req_addr[r_req_wr] <= w_cl_addr[w_grant_idx];
            r_req_data[r_req_wr] <= w_cl_data[w_grant_idx];
        end
        if (w_rsp_push) begin
            r_rsp_src[r_rsp_wr]  <= mem_rsp_src;
            r_rsp_data[r_rsp_wr] <= mem_rsp_data;
        end
    end

    assign cl_req_ready  = w_cl_req_ready;
    assign cl_rsp_valid  = w_cl_rsp_valid;
    assign cl_rsp_data   = r_rsp_data[r_rsp_rd];
    assign mem_req_valid = w_mem_req_valid;
    assign mem_req_cmd   = r_req_cmd[r_req_rd];
    assign mem_req_src   = r_req_src[r_req_rd];
    assign mem_req_addr  = r_req_addr[r_req_rd];
    assign mem_req_data  = r_req_data[r_req_rd];
    assign mem_rsp_ready = w_rsp_room;
    assign req_count     = r_req_count;
    assign err_sticky    = r_err;

    memory_bus_fabric_checker #(.NUM_CLIENTS(NUM_CLIENTS)) u_checker (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_push     (w_req_push),
        .i_req_full     (w_req_full),
        .i_req_pop      (w_req_pop),
        .i_req_empty    (w_req_empty),
        .i_rsp_push     (w_rsp_push),
        .i_rsp_full     (w_rsp_full),
        .i_rsp_pop      (w_rsp_pop),
        .i_rsp_empty    (w_rsp_empty),
        .i_cl_req_ready (w_cl_req_ready)
    );
endmodule

// File: tb/tb_memory_bus_fabric.sv
// Directed bench for memory_bus_fabric: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_memory_bus_fabric;
    localparam int N = 4, SRC_W = 3, ADDR_W = 32, DATA_W = 64, REQ_DEPTH = 4, RSP_DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0]        cl_req_valid = '0, cl_req_ready, cl_rsp_valid, cl_rsp_ready = '0;
    logic [2*N-1:0]      cl_req_cmd;
    logic [ADDR_W*N-1:0] cl_req_addr;
    logic [DATA_W*N-1:0] cl_req_data;
    logic [DATA_W-1:0]   cl_rsp_data;
    logic                mem_req_valid, mem_req_ready = 1'b0;
    logic [1:0]          mem_req_cmd;
    logic [SRC_W-1:0]    mem_req_src;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_data;
    logic                mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [SRC_W-1:0]    mem_rsp_src = '0;
    logic [DATA_W-1:0]   mem_rsp_data = '0;
    logic [2:0]          req_count;
    logic                err_sticky;

    logic [1:0]        t_cmd  [N];
    logic [ADDR_W-1:0] t_addr [N];
    logic [DATA_W-1:0] t_data [N];
    logic [N-1:0]      one_shot = '0;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [1:0] cmd; int src; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } req_t;
    typedef struct { int src; logic [DATA_W-1:0] data; } rsp_t;
    req_t m_req[$];
    rsp_t m_rsp[$];
    int   m_rr = 0;
    bit   m_err = 1'b0;
    logic [N-1:0]      grant_log[$];
    logic [ADDR_W-1:0] pop_log[$];

    always #5 clk = ~clk;

    always_comb begin
        cl_req_cmd  = '0;
        cl_req_addr = '0;
        cl_req_data = '0;
        for (int c = 0; c < N; c++) begin
            cl_req_cmd[2*c +: 2]           = t_cmd[c];
            cl_req_addr[ADDR_W*c +: ADDR_W] = t_addr[c];
            cl_req_data[DATA_W*c +: DATA_W] = t_data[c];
        end
    end

    memory_bus_fabric #(
        .NUM_CLIENTS(N), .SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready), .cl_req_cmd(cl_req_cmd),
        .cl_req_addr(cl_req_addr), .cl_req_data(cl_req_data),
        .cl_rsp_valid(cl_rsp_valid), .cl_rsp_ready(cl_rsp_ready), .cl_rsp_data(cl_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_cmd(mem_req_cmd),
        .mem_req_src(mem_req_src), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_src(mem_rsp_src),
        .mem_rsp_data(mem_rsp_data), .req_count(req_count), .err_sticky(err_sticky)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: compare at the falling edge, then advance by what the rising edge will do.
    always @(negedge clk) begin : p_model
        logic [N-1:0] e_ready, e_rspv;
        bit           e_mvalid, e_rsprdy;
        int           g;
        req_t         nr;
        rsp_t         ns;
        e_ready = '0;
        e_rspv  = '0;
        g = -1;
        if (!reset && m_req.size() < REQ_DEPTH) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && cl_req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) e_ready[g] = 1'b1;
        e_mvalid = !reset && (m_req.size() > 0);
        e_rsprdy = !reset && (m_rsp.size() < RSP_DEPTH);
        if (!reset && m_rsp.size() > 0) e_rspv[m_rsp[0].src] = 1'b1;

        check("cl_req_ready", 64'(cl_req_ready), 64'(e_ready));
        check("mem_req_valid", 64'(mem_req_valid), 64'(e_mvalid));
        check("mem_rsp_ready", 64'(mem_rsp_ready), 64'(e_rsprdy));
        check("cl_rsp_valid", 64'(cl_rsp_valid), 64'(e_rspv));
        check("req_count", 64'(req_count), 64'(m_req.size()));
        check("err_sticky", 64'(err_sticky), 64'(m_err));
        if (e_mvalid) begin
            check("mem_req_cmd", 64'(mem_req_cmd), 64'(m_req[0].cmd));
            check("mem_req_src", 64'(mem_req_src), 64'(m_req[0].src));
            check("mem_req_addr", 64'(mem_req_addr), 64'(m_req[0].addr));
            check("mem_req_data", mem_req_data, m_req[0].data);
        end
        if (e_rspv != '0) check("cl_rsp_data", cl_rsp_data, m_rsp[0].data);

        if (cl_req_ready != '0) grant_log.push_back(cl_req_ready);
        if (mem_req_valid && mem_req_ready) pop_log.push_back(mem_req_addr);

        if (reset) begin
            m_req.delete();
            m_rsp.delete();
            m_rr  = 0;
            m_err = 1'b0;
        end else begin
            if (e_mvalid && mem_req_ready) m_req.delete(0);
            if (g >= 0) begin
                if (t_cmd[g] >= 2'd2) m_err = 1'b1;
                else begin
                    nr.cmd = t_cmd[g]; nr.src = g; nr.addr = t_addr[g]; nr.data = t_data[g];
                    m_req.push_back(nr);
                end
                m_rr = (g + 1) % N;
            end
            if (e_rspv != '0 && cl_rsp_ready[m_rsp[0].src]) m_rsp.delete(0);
            if (mem_rsp_valid && e_rsprdy) begin
                if (int'(mem_rsp_src) >= N) m_err = 1'b1;
                else begin
                    ns.src = int'(mem_rsp_src); ns.data = mem_rsp_data;
                    m_rsp.push_back(ns);
                end
            end
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic fin();
        logic [N-1:0] hs;
        hs = cl_req_valid & cl_req_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (hs[c]) begin
                if (one_shot[c]) cl_req_valid[c] = 1'b0;
                else begin
                    t_addr[c] = t_addr[c] + 32'h10;
                    t_data[c] = t_data[c] + 64'h1;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin to_neg(); fin(); end
    endtask

    task automatic do_reset();
        cl_req_valid = '0; cl_rsp_ready = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int c = 0; c < N; c++) begin
            t_cmd[c] = 2'd0; t_addr[c] = 32'h0; t_data[c] = 64'h0;
        end
        do_reset();
        to_neg();
        check("rst_req_count", 64'(req_count), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        fin();

        // Single read round trip.
        mem_req_ready = 1'b1; one_shot = '1;
        t_cmd[1] = 2'd0; t_addr[1] = 32'h100; t_data[1] = 64'h0; cl_req_valid[1] = 1'b1;
        to_neg(); check("rd_grant", 64'(cl_req_ready), 64'h2); fin();
        to_neg();
        check("rd_mvalid", 64'(mem_req_valid), 64'd1);
        check("rd_src", 64'(mem_req_src), 64'd1);
        check("rd_addr", 64'(mem_req_addr), 64'h100);
        fin();
        mem_rsp_valid = 1'b1; mem_rsp_src = 3'd1; mem_rsp_data = 64'hDEAD;
        to_neg(); check("rd_rsp_ready", 64'(mem_rsp_ready), 64'd1); fin();
        mem_rsp_valid = 1'b0; cl_rsp_ready = 4'b0010;
        to_neg();
        check("rd_rsp_valid", 64'(cl_rsp_valid), 64'h2);
        check("rd_rsp_data", cl_rsp_data, 64'hDEAD);
        fin();
        to_neg(); check("rd_rsp_gone", 64'(cl_rsp_valid), 64'd0); fin();

        // Fairness with all clients requesting.
        do_reset();
        mem_req_ready = 1'b1; one_shot = '0;
        for (int c = 0; c < N; c++) begin t_cmd[c] = 2'd1; t_addr[c] = 32'(c) << 8; end
        grant_log.delete();
        cl_req_valid = '1;
        cyc(8);
        cl_req_valid = '0;
        cyc(3);
        check("fair_len", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("fair_order", 64'(grant_log[i]), 64'(4'b0001 << (i % 4)));
        for (int c = 0; c < N; c++) begin
            cnt = 0;
            foreach (grant_log[i]) if (grant_log[i][c]) cnt++;
            check("fair_count", 64'(cnt), 64'd2);
        end

        // Backpressure: fill the request FIFO, then drain in order.
        do_reset();
        one_shot = '0; t_cmd[0] = 2'd1; t_addr[0] = 32'h1000; t_data[0] = 64'h55;
        pop_log.delete();
        cl_req_valid[0] = 1'b1;
        cyc(4);
        to_neg();
        check("bp_count", 64'(req_count), 64'd4);
        check("bp_ready", 64'(cl_req_ready), 64'd0);
        fin();
        cyc(1);
        cl_req_valid[0] = 1'b0; mem_req_ready = 1'b1;
        cyc(6);
        check("bp_pops", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("bp_addr", 64'(pop_log[i]), 64'(32'h1000 + 32'(i) * 32'h10));

        // Response FIFO full and release.
        do_reset();
        mem_rsp_valid = 1'b1; mem_rsp_src = 3'd2;
        for (int i = 0; i < 4; i++) begin mem_rsp_data = 64'hA0 + 64'(i); cyc(1); end
        mem_rsp_data = 64'hA4;
        to_neg();
        check("full_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        check("full_rsp_valid", 64'(cl_rsp_valid), 64'h4);
        fin();
        mem_rsp_valid = 1'b0; cl_rsp_ready = 4'b0100;
        to_neg(); check("full_head", cl_rsp_data, 64'hA0); fin();
        cl_rsp_ready = '0;
        to_neg();
        check("full_room", 64'(mem_rsp_ready), 64'd1);
        check("full_next", cl_rsp_data, 64'hA1);
        fin();
        cl_rsp_ready = 4'b0100;
        cyc(4);
        to_neg(); check("full_drained", 64'(cl_rsp_valid), 64'd0); fin();
        cl_rsp_ready = '0;

        // Illegal client command.
        do_reset();
        mem_req_ready = 1'b1; one_shot = '1;
        t_cmd[3] = 2'd3; t_addr[3] = 32'h300; cl_req_valid[3] = 1'b1;
        to_neg();
        check("ill_grant", 64'(cl_req_ready), 64'h8);
        check("ill_err_before", 64'(err_sticky), 64'd0);
        fin();
        to_neg();
        check("ill_err", 64'(err_sticky), 64'd1);
        check("ill_not_fwd", 64'(mem_req_valid), 64'd0);
        check("ill_count", 64'(req_count), 64'd0);
        fin();

        // Bad response source.
        do_reset();
        mem_rsp_valid = 1'b1; mem_rsp_src = 3'd6; mem_rsp_data = 64'hBEEF;
        to_neg(); check("bad_src_ready", 64'(mem_rsp_ready), 64'd1); fin();
        mem_rsp_valid = 1'b0;
        to_neg();
        check("bad_src_err", 64'(err_sticky), 64'd1);
        check("bad_src_novalid", 64'(cl_rsp_valid), 64'd0);
        fin();

        // Reset with three requests queued and the error flag set.
        mem_req_ready = 1'b0; one_shot = '1;
        for (int c = 0; c < 3; c++) begin t_cmd[c] = 2'd1; t_addr[c] = 32'h2000 + 32'(c); end
        cl_req_valid = 4'b0111;
        cyc(3);
        to_neg();
        check("mid_count", 64'(req_count), 64'd3);
        check("mid_err", 64'(err_sticky), 64'd1);
        fin();
        t_cmd[1] = 2'd0; t_cmd[3] = 2'd0;
        cl_req_valid = 4'b1010;
        reset = 1'b1;
        to_neg();
        check("mid_rst_mvalid", 64'(mem_req_valid), 64'd0);
        check("mid_rst_ready", 64'(cl_req_ready), 64'd0);
        fin();
        reset = 1'b0;
        to_neg();
        check("mid_post_count", 64'(req_count), 64'd0);
        check("mid_post_err", 64'(err_sticky), 64'd0);
        check("mid_post_mvalid", 64'(mem_req_valid), 64'd0);
        check("mid_post_rr", 64'(cl_req_ready), 64'h2);
        fin();
        cl_req_valid = '0;
        mem_req_ready = 1'b1;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
